// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: video has absolute priority, register and blitter
// requesters share the remaining cycles round-robin. Reads are tagged so the
// returning data strobe reaches the requester that issued it.
module vram_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int WAIT_W = 8
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              vgen_sel_i,
    input  logic [ADDR_W-1:0] vgen_addr_i,
    input  logic              regs_sel_i,
    input  logic              regs_wr_i,
    input  logic [3:0]        regs_wrmask_i,
    input  logic [ADDR_W-1:0] regs_addr_i,
    input  logic [15:0]       regs_data_i,
    output logic              regs_ack_o,
    input  logic              blit_sel_i,
    input  logic              blit_wr_i,
    input  logic [3:0]        blit_wrmask_i,
    input  logic [ADDR_W-1:0] blit_addr_i,
    input  logic [15:0]       blit_data_i,
    output logic              blit_ack_o,
    output logic              vram_sel_o,
    output logic              vram_wr_o,
    output logic [3:0]        vram_mask_o,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [15:0]       vram_data_o,
    input  logic [15:0]       vram_data_i,
    output logic [15:0]       rd_data_o,
    output logic              vgen_rd_valid_o,
    output logic              regs_rd_valid_o,
    output logic              blit_rd_valid_o,
    input  logic              stat_clear_i,
    output logic [WAIT_W-1:0] perf_max_wait_o
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGEN = 2'd1,
        OWN_REGS = 2'd2,
        OWN_BLIT = 2'd3
    } owner_t;

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (&v) ? v : v + WAIT_W'(1);
    endfunction

    logic              grant_regs, grant_blit;
    // Set when regs wins, cleared when blit wins; a tie goes to blit only when set.
    logic              rr_blit_turn_q, rr_blit_turn_d;
    logic              vram_sel_q, vram_sel_d;
    logic              vram_wr_q, vram_wr_d;
    logic [3:0]        vram_mask_q, vram_mask_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic [15:0]       vram_data_q, vram_data_d;
    owner_t            cmd_owner_q, cmd_owner_d;
    owner_t            tag_q, tag_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WAIT_W-1:0] max_wait_q, max_wait_d;

    always_comb begin
        grant_regs = !vgen_sel_i && regs_sel_i && (!blit_sel_i || !rr_blit_turn_q);
        grant_blit = !vgen_sel_i && blit_sel_i && (!regs_sel_i || rr_blit_turn_q);

        rr_blit_turn_d = rr_blit_turn_q;
        if (grant_regs) begin
            rr_blit_turn_d = 1'b1;
        end else if (grant_blit) begin
            rr_blit_turn_d = 1'b0;
        end
    end

    always_comb begin
        vram_sel_d  = 1'b0;
        vram_wr_d   = 1'b0;
        vram_mask_d = vram_mask_q;
        vram_addr_d = vram_addr_q;
        vram_data_d = vram_data_q;
        cmd_owner_d = OWN_NONE;
        if (vgen_sel_i) begin
            vram_sel_d  = 1'b1;
            vram_mask_d = 4'hF;
            vram_addr_d = vgen_addr_i;
            cmd_owner_d = OWN_VGEN;
        end else if (grant_regs) begin
            vram_sel_d  = 1'b1;
            vram_wr_d   = regs_wr_i;
            vram_mask_d = regs_wrmask_i;
            vram_addr_d = regs_addr_i;
            vram_data_d = regs_data_i;
            cmd_owner_d = OWN_REGS;
        end else if (grant_blit) begin
            vram_sel_d  = 1'b1;
            vram_wr_d   = blit_wr_i;
            vram_mask_d = blit_wrmask_i;
            vram_addr_d = blit_addr_i;
            vram_data_d = blit_data_i;
            cmd_owner_d = OWN_BLIT;
        end

        // Memory returns read data one cycle after the strobe, so the tag lags one stage.
        tag_d = (vram_sel_q && !vram_wr_q) ? cmd_owner_q : OWN_NONE;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        max_wait_d = max_wait_q;
        if (!regs_sel_i || grant_regs) begin
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = sat_inc(wait_cnt_q);
        end
        if (stat_clear_i) begin
            max_wait_d = '0;
        end else if (grant_regs && (wait_cnt_q > max_wait_q)) begin
            max_wait_d = wait_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_blit_turn_q <= 1'b0;
            vram_sel_q     <= 1'b0;
            vram_wr_q      <= 1'b0;
            vram_mask_q    <= '0;
            vram_addr_q    <= '0;
            vram_data_q    <= '0;
            cmd_owner_q    <= OWN_NONE;
            tag_q          <= OWN_NONE;
            wait_cnt_q     <= '0;
            max_wait_q     <= '0;
        end else begin
            rr_blit_turn_q <= rr_blit_turn_d;
            vram_sel_q     <= vram_sel_d;
            vram_wr_q      <= vram_wr_d;
            vram_mask_q    <= vram_mask_d;
            vram_addr_q    <= vram_addr_d;
            vram_data_q    <= vram_data_d;
            cmd_owner_q    <= cmd_owner_d;
            tag_q          <= tag_d;
            wait_cnt_q     <= wait_cnt_d;
            max_wait_q     <= max_wait_d;
        end
    end

    assign regs_ack_o      = grant_regs;
    assign blit_ack_o      = grant_blit;
    assign vram_sel_o      = vram_sel_q;
    assign vram_wr_o       = vram_wr_q;
    assign vram_mask_o     = vram_mask_q;
    assign vram_addr_o     = vram_addr_q;
    assign vram_data_o     = vram_data_q;
    assign rd_data_o       = vram_data_i;
    assign vgen_rd_valid_o = (tag_q == OWN_VGEN);
    assign regs_rd_valid_o = (tag_q == OWN_REGS);
    assign blit_rd_valid_o = (tag_q == OWN_BLIT);
    assign perf_max_wait_o = max_wait_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: a reference model predicts grants, memory
// commands and read returns; a monitor pops the expectations as outputs appear.
module tb_vram_port_arbiter;
    localparam int AW = 16;
    localparam int WW = 8;
    localparam int W_NONE = 0, W_VGEN = 1, W_REGS = 2, W_BLIT = 3;

    logic          clk = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          vgen_sel_i = 1'b0;
    logic [AW-1:0] vgen_addr_i = '0;
    logic          regs_sel_i = 1'b0, regs_wr_i = 1'b0;
    logic [3:0]    regs_wrmask_i = '0;
    logic [AW-1:0] regs_addr_i = '0;
    logic [15:0]   regs_data_i = '0;
    logic          regs_ack_o;
    logic          blit_sel_i = 1'b0, blit_wr_i = 1'b0;
    logic [3:0]    blit_wrmask_i = '0;
    logic [AW-1:0] blit_addr_i = '0;
    logic [15:0]   blit_data_i = '0;
    logic          blit_ack_o;
    logic          vram_sel_o, vram_wr_o;
    logic [3:0]    vram_mask_o;
    logic [AW-1:0] vram_addr_o;
    logic [15:0]   vram_data_o, vram_data_i, rd_data_o;
    logic          vgen_rd_valid_o, regs_rd_valid_o, blit_rd_valid_o;
    logic          stat_clear_i = 1'b0;
    logic [WW-1:0] perf_max_wait_o;

    always #5 clk = ~clk;

    vram_port_arbiter #(.ADDR_W(AW), .WAIT_W(WW)) dut (
        .clk(clk), .reset_n_i(reset_n_i),
        .vgen_sel_i(vgen_sel_i), .vgen_addr_i(vgen_addr_i),
        .regs_sel_i(regs_sel_i), .regs_wr_i(regs_wr_i), .regs_wrmask_i(regs_wrmask_i),
        .regs_addr_i(regs_addr_i), .regs_data_i(regs_data_i), .regs_ack_o(regs_ack_o),
        .blit_sel_i(blit_sel_i), .blit_wr_i(blit_wr_i), .blit_wrmask_i(blit_wrmask_i),
        .blit_addr_i(blit_addr_i), .blit_data_i(blit_data_i), .blit_ack_o(blit_ack_o),
        .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_mask_o(vram_mask_o),
        .vram_addr_o(vram_addr_o), .vram_data_o(vram_data_o), .vram_data_i(vram_data_i),
        .rd_data_o(rd_data_o), .vgen_rd_valid_o(vgen_rd_valid_o),
        .regs_rd_valid_o(regs_rd_valid_o), .blit_rd_valid_o(blit_rd_valid_o),
        .stat_clear_i(stat_clear_i), .perf_max_wait_o(perf_max_wait_o)
    );

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C3C;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic [3:0] mask);
        logic [15:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (mask[i]) r[i*4 +: 4] = new_v[i*4 +: 4];
        return r;
    endfunction

    // Synchronous VRAM device: read data valid one cycle after the strobe.
    logic [15:0] dev_mem [0:65535];
    bit          dev_written [0:65535];
    logic [15:0] dev_rd_q;
    always @(posedge clk) begin
        if (vram_sel_o) begin
            if (vram_wr_o) begin
                dev_mem[vram_addr_o]     <= merge(dev_written[vram_addr_o] ? dev_mem[vram_addr_o]
                                                  : init_val(vram_addr_o), vram_data_o, vram_mask_o);
                dev_written[vram_addr_o] <= 1'b1;
            end else begin
                dev_rd_q <= dev_written[vram_addr_o] ? dev_mem[vram_addr_o] : init_val(vram_addr_o);
            end
        end
    end
    assign vram_data_i = dev_rd_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model state
    typedef struct { int stamp; logic wr; logic [3:0] mask; logic [15:0] addr; logic [15:0] data; } cmd_t;
    typedef struct { int stamp; int owner; logic [15:0] data; } rd_t;
    cmd_t cmd_q[$];
    rd_t  rd_q[$];
    logic [15:0] m_mem [0:65535];
    int   last_rb = W_NONE, m_wait = 0, m_max = 0, last_win = W_NONE;
    logic v_sel = 0; logic [15:0] v_addr = 0; logic clr = 0;
    logic r_pend = 0, r_wr = 0; logic [3:0] r_mask = 0; logic [15:0] r_addr = 0, r_data = 0;
    logic b_pend = 0, b_wr = 0; logic [3:0] b_mask = 0; logic [15:0] b_addr = 0, b_data = 0;
    logic [15:0] last_regs_rd = 0;
    bit mon_en = 0;

    // One bus cycle: drive at negedge, check grants, record expectations.
    task automatic step();
        int win;
        cmd_t c;
        rd_t r;
        vgen_sel_i = v_sel; vgen_addr_i = v_addr; stat_clear_i = clr;
        regs_sel_i = r_pend; regs_wr_i = r_wr; regs_wrmask_i = r_mask;
        regs_addr_i = r_addr; regs_data_i = r_data;
        blit_sel_i = b_pend; blit_wr_i = b_wr; blit_wrmask_i = b_mask;
        blit_addr_i = b_addr; blit_data_i = b_data;
        #2;
        if (v_sel) win = W_VGEN;
        else if (r_pend && b_pend) win = (last_rb == W_REGS) ? W_BLIT : W_REGS;
        else if (r_pend) win = W_REGS;
        else if (b_pend) win = W_BLIT;
        else win = W_NONE;
        chk("regs_ack", 64'(regs_ack_o), 64'(win == W_REGS));
        chk("blit_ack", 64'(blit_ack_o), 64'(win == W_BLIT));

        if (clr) m_max = 0;
        else if (win == W_REGS && m_wait > m_max) m_max = m_wait;
        if (r_pend && win != W_REGS) m_wait = (m_wait < 255) ? m_wait + 1 : 255;
        else m_wait = 0;

        if (win != W_NONE) begin
            c.stamp = cyc;
            case (win)
                W_VGEN:  begin c.wr = 0;    c.mask = 4'hF;   c.addr = v_addr; c.data = 0;      end
                W_REGS:  begin c.wr = r_wr; c.mask = r_mask; c.addr = r_addr; c.data = r_data; end
                default: begin c.wr = b_wr; c.mask = b_mask; c.addr = b_addr; c.data = b_data; end
            endcase
            cmd_q.push_back(c);
            if (c.wr) m_mem[c.addr] = merge(m_mem[c.addr], c.data, c.mask);
            else begin
                r.stamp = cyc; r.owner = win; r.data = m_mem[c.addr];
                rd_q.push_back(r);
            end
        end
        if (win == W_REGS) begin last_rb = W_REGS; r_pend = 0; end
        if (win == W_BLIT) begin last_rb = W_BLIT; b_pend = 0; end
        last_win = win;
        @(negedge clk);
    endtask

    task automatic monitor_check();
        cmd_t c;
        rd_t r;
        logic [2:0] exp_v;
        if (cmd_q.size() > 0 && cmd_q[0].stamp == cyc - 1) begin
            c = cmd_q.pop_front();
            chk("vram_sel", 64'(vram_sel_o), 64'd1);
            chk("vram_wr", 64'(vram_wr_o), 64'(c.wr));
            chk("vram_addr", 64'(vram_addr_o), 64'(c.addr));
            chk("vram_mask", 64'(vram_mask_o), 64'(c.mask));
            if (c.wr) chk("vram_data", 64'(vram_data_o), 64'(c.data));
        end else begin
            chk("vram_idle", 64'({vram_sel_o, vram_wr_o}), 64'd0);
        end
        if (rd_q.size() > 0 && rd_q[0].stamp == cyc - 2) begin
            r = rd_q.pop_front();
            exp_v = 3'(1 << (r.owner - 1));
            chk("rd_valid", 64'({blit_rd_valid_o, regs_rd_valid_o, vgen_rd_valid_o}), 64'(exp_v));
            chk("rd_data", 64'(rd_data_o), 64'(r.data));
            if (r.owner == W_REGS) last_regs_rd = rd_data_o;
        end else begin
            chk("rd_valid_idle", 64'({blit_rd_valid_o, regs_rd_valid_o, vgen_rd_valid_o}), 64'd0);
        end
        chk("perf_max_wait", 64'(perf_max_wait_o), 64'(m_max));
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (mon_en) monitor_check();
    end

    task automatic do_reset();
        reset_n_i = 0;
        v_sel = 0; r_pend = 0; b_pend = 0; clr = 0;
        vgen_sel_i = 0; regs_sel_i = 0; blit_sel_i = 0; stat_clear_i = 0;
        cmd_q.delete(); rd_q.delete();
        last_rb = W_NONE; m_wait = 0; m_max = 0;
        #1;
        chk("rst_vram", 64'({vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_o}), 64'd0);
        chk("rst_valid", 64'({vgen_rd_valid_o, regs_rd_valid_o, blit_rd_valid_o}), 64'd0);
        chk("rst_perf", 64'(perf_max_wait_o), 64'd0);
        repeat (3) @(negedge clk);
        reset_n_i = 1;
        mon_en = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_valid", 64'({vgen_rd_valid_o, regs_rd_valid_o, blit_rd_valid_o}), 64'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_traffic(input int n);
        int vprob;
        vprob = 30;
        for (int i = 0; i < n; i++) begin
            if (i % 100 == 0) vprob = $urandom_range(0, 90);
            v_sel = ($urandom_range(0, 99) < vprob);
            v_addr = 16'($urandom_range(0, 15));
            clr = ($urandom_range(0, 63) == 0);
            if (!r_pend && $urandom_range(0, 1) == 1) begin
                r_pend = 1; r_wr = 1'($urandom); r_mask = 4'($urandom);
                r_addr = 16'($urandom_range(0, 15)); r_data = 16'($urandom);
            end
            if (!b_pend && $urandom_range(0, 1) == 1) begin
                b_pend = 1; b_wr = 1'($urandom); b_mask = 4'($urandom);
                b_addr = 16'($urandom_range(0, 15)); b_data = 16'($urandom);
            end
            step();
        end
        clr = 0; v_sel = 0;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) m_mem[a] = init_val(16'(a));
        @(negedge clk);
        do_reset();

        // Round-robin from reset: both hold requests continuously.
        r_pend = 1; r_wr = 0; r_addr = 16'h0010; r_mask = 4'hF;
        b_pend = 1; b_wr = 0; b_addr = 16'h0020; b_mask = 4'hF;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_order", 64'(last_win), 64'((k % 2 == 0) ? W_REGS : W_BLIT));
            r_pend = 1; b_pend = 1;
        end
        r_pend = 0; b_pend = 0;
        idle(3);

        // Video priority over a pending regs read.
        v_sel = 1; v_addr = 16'h0100;
        r_pend = 1; r_wr = 0; r_addr = 16'h0200;
        step();
        chk("vid_pri_win", 64'(last_win), 64'(W_VGEN));
        v_sel = 0;
        idle(4);

        // Blitter write then register read of the same word, full and nibble masks.
        b_pend = 1; b_wr = 1; b_mask = 4'hF; b_addr = 16'hABCD; b_data = 16'hD070;
        step();
        r_pend = 1; r_wr = 0; r_addr = 16'hABCD;
        step();
        idle(3);
        chk("wr_rd_full", 64'(last_regs_rd), 64'h0000_0000_0000_D070);
        b_pend = 1; b_wr = 1; b_mask = 4'h1; b_addr = 16'hABCD; b_data = 16'h1234;
        step();
        r_pend = 1; r_wr = 0; r_addr = 16'hABCD;
        step();
        idle(3);
        chk("wr_rd_nibble", 64'(last_regs_rd), 64'h0000_0000_0000_D074);

        // Wait statistic: 5-cycle stall, saturating stall, clear on the ack cycle.
        clr = 1; step(); clr = 0;
        r_pend = 1; r_wr = 0; r_addr = 16'h0003;
        v_sel = 1;
        for (int i = 0; i < 5; i++) begin v_addr = 16'(i); step(); end
        v_sel = 0; step(); idle(1);
        chk("wait_5", 64'(perf_max_wait_o), 64'd5);
        r_pend = 1; v_sel = 1;
        for (int i = 0; i < 300; i++) begin v_addr = 16'(i); step(); end
        v_sel = 0; step(); idle(1);
        chk("wait_sat", 64'(perf_max_wait_o), 64'd255);
        r_pend = 1; clr = 1; step(); clr = 0; idle(1);
        chk("wait_clear", 64'(perf_max_wait_o), 64'd0);
        idle(3);

        // Random traffic, reset mid-stream with reads in flight, more traffic.
        rand_traffic(700);
        v_sel = 1; v_addr = 16'h0005; r_pend = 1; r_wr = 0; r_addr = 16'h0006;
        step(); step();
        do_reset();
        rand_traffic(1200);
        r_pend = 0; b_pend = 0;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
